// File: rtl/div_sign_conditioner.sv
// Sign-handling wrapper in front of a multicycle unsigned divider: magnitudes out, signed results back.
// Optional macro DIV_SIGNED_OVF_DETECT_EN short-circuits most-negative / -1 with an overflow flag.
module div_sign_conditioner #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             div_start,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             a_zero,
  output logic             b_zero,
  output logic             exc_div0,
  output logic             exc_ovf
);

  localparam logic [WIDTH-1:0] L_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           r_state;
  logic             r_q_neg, r_r_neg;
  logic [WIDTH-1:0] r_mag_a, r_mag_b, r_quot, r_rem;
  logic             r_a_zero, r_b_zero, r_div0, r_ovf;

  logic             w_neg_a, w_neg_b, w_a_zero, w_b_zero, w_ovf_short;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;

  assign w_neg_a  = is_signed & a[WIDTH-1];
  assign w_neg_b  = is_signed & b[WIDTH-1];
  // most-negative operand negates to itself, which is the correct unsigned magnitude
  assign w_mag_a  = w_neg_a ? (~a + 1'b1) : a;
  assign w_mag_b  = w_neg_b ? (~b + 1'b1) : b;
  assign w_a_zero = (a == '0);
  assign w_b_zero = (b == '0);

`ifdef DIV_SIGNED_OVF_DETECT_EN
  assign w_ovf_short = is_signed & (a == L_MIN) & (&b) & ~w_b_zero;
`else
  assign w_ovf_short = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
      r_mag_a  <= '0;
      r_mag_b  <= '0;
      r_quot   <= '0;
      r_rem    <= '0;
      r_a_zero <= 1'b0;
      r_b_zero <= 1'b0;
      r_div0   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_q_neg  <= w_neg_a ^ w_neg_b;
          r_r_neg  <= w_neg_a;
          r_mag_a  <= w_mag_a;
          r_mag_b  <= w_mag_b;
          r_a_zero <= w_a_zero;
          r_b_zero <= w_b_zero;
          r_div0   <= w_b_zero;
          r_ovf    <= 1'b0;
          r_quot   <= '0;
          r_rem    <= '0;
          if (w_b_zero || w_a_zero) begin
            r_state <= S_RESP;
          end else if (w_ovf_short) begin
            r_quot  <= L_MIN;
            r_ovf   <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: if (div_done) begin
          r_quot  <= r_q_neg ? (~div_quotient + 1'b1) : div_quotient;
          r_rem   <= r_r_neg ? (~div_remainder + 1'b1) : div_remainder;
          r_state <= S_RESP;
        end
        S_RESP: if (out_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready     = (r_state == S_IDLE);
  assign div_start    = (r_state == S_ISSUE);
  assign out_valid    = (r_state == S_RESP);
  assign div_dividend = r_mag_a;
  assign div_divisor  = r_mag_b;
  assign quotient     = r_quot;
  assign remainder    = r_rem;
  assign a_zero       = r_a_zero;
  assign b_zero       = r_b_zero;
  assign exc_div0     = r_div0;
  assign exc_ovf      = r_ovf;

endmodule

// File: doc/div_sign_conditioner.md
# div_sign_conditioner

Sequential sign-handling wrapper placed in front of the multicycle unsigned divider in the ALU/multdiv path. It accepts a dividend/divisor pair through a valid/ready handshake and converts signed operands to magnitudes. It then launches the divider, or short-circuits zero and exception cases, and re-applies signs to the returned quotient and remainder. Width is parametrised, and signed or unsigned mode is selectable per operation.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 4)
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  block can accept a request
- a  in  WIDTH  dividend
- b  in  WIDTH  divisor
- is_signed  in  1  1 = two's-complement division, 0 = unsigned
- div_start  out  1  one-cycle launch pulse to the unsigned divider
- div_dividend  out  WIDTH  dividend magnitude; held stable from launch until div_done
- div_divisor  out  WIDTH  divisor magnitude; held stable from launch until div_done
- div_done  in  1  divider result valid (single-cycle pulse)
- div_quotient  in  WIDTH  unsigned quotient
- div_remainder  in  WIDTH  unsigned remainder
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- quotient  out  WIDTH  signed-corrected quotient
- remainder  out  WIDTH  signed-corrected remainder; sign follows dividend
- a_zero  out  1  captured dividend was zero
- b_zero  out  1  captured divisor was zero
- exc_div0  out  1  divide-by-zero exception
- exc_ovf  out  1  signed overflow (most-negative / −1)

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: in_ready=1. On in_valid, capture at the clock edge:
  - neg_a = is_signed & a[W−1]
  - neg_b = is_signed & b[W−1]
  - mag_a = neg_a ? (~a+1) : a
  - mag_b = neg_b ? (~b+1) : b
  - q_neg = neg_a ^ neg_b
  - r_neg = neg_a
  - a_zero = (a==0)
  - b_zero = (b==0)
- Transition priority out of IDLE:
  - b_zero → RESP with quotient=0, remainder=0, exc_div0=1.
  - Otherwise a_zero → RESP with quotient=0, remainder=0, no exception.
  - Otherwise overflow case (see Configuration) → RESP.
  - Otherwise → ISSUE.
- ISSUE: div_start=1 for exactly this cycle; div_dividend=mag_a, div_divisor=mag_b. Next state WAIT.
- WAIT: on div_done, capture the corrected results and go to RESP:
  - quotient = q_neg ? −div_quotient : div_quotient
  - remainder = r_neg ? −div_remainder : div_remainder
- RESP: out_valid=1. All result and flag outputs are held stable until out_ready=1, then the block returns to IDLE.
- in_ready=0 in every state except IDLE. There is no request overlap: out_valid and in_ready are never both 1.
- The most-negative operand negates to itself and is passed as the unsigned magnitude 2^(W−1); this is correct.
- div_done is ignored outside WAIT.

## Timing
- Reset values: state=IDLE, in_ready=1 from the first cycle after reset, and every other output is 0.
- Reset mid-operation in any state → IDLE next cycle. Any pending result is discarded, and a later stray div_done is ignored.
- Shortcut latency: request accepted at edge k → out_valid=1 in cycle k+1.
- Normal latency: accepted at edge k → div_start in cycle k+1; div_done sampled at edge d → out_valid from cycle d+1.
- Sign correction adds no cycles beyond the RESP register.
- out_ready high on the first RESP cycle gives a single-cycle RESP, and in_ready=1 the cycle after.

## Configuration
- DIV_SIGNED_OVF_DETECT_EN defined:
  - In IDLE, is_signed & a==100…0 & b==all-ones & !b_zero → RESP directly.
  - Results: quotient=100…0, remainder=0, exc_ovf=1.
  - Shortcut latency applies.
- Not defined:
  - exc_ovf is tied to 0.
  - The case goes through the divider (magnitudes 2^(W−1)/1, q_neg=0), giving quotient=100…0, remainder=0 at normal latency and with no flag.

## Test plan
- WIDTH=32, signed, a=−7 (0xFFFFFFF9), b=2 → div_dividend=7, div_divisor=2, one div_start pulse. Divider model returns q=3, r=1 → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF, no exception.
- Unsigned, a=0xFFFFFFF9, b=2 → magnitudes passed unchanged. Returned q=0x7FFFFFFC, r=1 → identical outputs.
- a=5, b=0, signed → no div_start, out_valid in cycle k+1, b_zero=1, exc_div0=1, quotient=0, remainder=0. a=0, b=3 → a_zero=1, quotient=0, no exception, no div_start.
- Signed a=0x80000000, b=0xFFFFFFFF:
  - With the macro defined → exc_ovf=1 at shortcut latency, quotient=0x80000000, no div_start.
  - Without it → div_start issued, final quotient=0x80000000, exc_ovf=0.
- Hold out_ready=0 for 5 cycles in RESP → outputs stable, in_ready=0, in_valid ignored. Then out_ready=1 → IDLE and in_ready=1 the next cycle.
- Assert reset during WAIT, then pulse div_done → state IDLE, out_valid stays 0, next request processed correctly.
